apb_slave_mem: RTL
==================

Name: apb_slave_mem

Overview:
- Synthesizable APB3 completer (slave) backed by a flop-based word memory, with a programmable number of wait states and error signalling.
- It is the responder end of the APB interfaces driven by our converters and master drivers.
- It replaces behavioural slave memory models in benches.
- It also serves as a scratch register bank on real APB segments.

Parameters:
- ADDR_WIDTH, 13: PADDR width in bits.
- DATA_WIDTH, 32: PWDATA/PRDATA width; must be 8, 16 or 32.
- MEM_WORDS, 64: number of DATA_WIDTH-wide words; power of two, at most 2^(ADDR_WIDTH - log2(DATA_WIDTH/8)).
- WAIT_STATES, 1: number of cycles PREADY is held low in ACCESS before completion; legal range 0..7.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only when PREADY=1.
- PREADY  out  1  transfer completion, registered.
- PSLVERR  out  1  error response; valid only when PREADY=1.

Behaviour:
- Interface: one clock, PCLK. Reset PRESETn is asynchronous, active-low.
- Reset values:
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - FSM=IDLE, wait counter=0.
  - All memory words cleared to 0.
- Reset asserted mid-transfer aborts the transfer immediately. No write is committed unless its completion edge has already occurred.
- Address decode:
  - Word index = PADDR >> log2(DATA_WIDTH/8).
  - Error if the low log2(DATA_WIDTH/8) bits are non-zero (unaligned).
  - Error if word index >= MEM_WORDS (out of range).
- FSM states: IDLE, ACCESS.
- IDLE:
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - On a rising edge with PSEL=1 and PENABLE=0 (SETUP), latch PADDR, PWRITE, PWDATA and the decode error, then go to ACCESS.
  - If WAIT_STATES=0, PREADY is set to 1 at that same edge. Otherwise the counter is loaded with WAIT_STATES and PREADY stays 0.
- ACCESS, counter != 0: decrement the counter. PREADY is set to 1 at the edge where the counter goes 1 -> 0.
- ACCESS, PREADY=1 (completion cycle):
  - Read: PRDATA = mem[latched index], or 0 on error.
  - PSLVERR = latched error.
  - At the end of this cycle (PSEL=1, PENABLE=1): a write with no error commits latched PWDATA to mem[index]; an erroneous write leaves memory unchanged.
  - The FSM then returns to IDLE, and PREADY, PRDATA and PSLVERR return to 0 on the next cycle.
- Latency (SETUP cycle = cycle 0): PREADY is high in cycle 1+WAIT_STATES, exactly one cycle per transfer.
- Back-to-back transfers: the cycle after completion may be a new SETUP. IDLE accepts it, giving 2+WAIT_STATES cycles per transfer.
- Protocol violation: PSEL=0 while in ACCESS aborts to IDLE. No write, PREADY=0, counter cleared.
- PENABLE=1 seen in IDLE without a preceding SETUP is ignored: stay IDLE, PREADY=0.
- Read-after-write to the same word returns the new data; the write has committed before the next SETUP can start.
- PWDATA/PADDR changes during ACCESS are ignored (latched values are used).

Test Plan:
- Reset then read word 4 (PADDR=0x010), WAIT_STATES=1 -> PREADY high in cycle 2 only, PRDATA=0x00000000, PSLVERR=0.
- Write 0x12345678 to PADDR=0x010, then read it back -> write completes in cycle 2 with PSLVERR=0; read returns 0x12345678 with PREADY high exactly one cycle.
- Write to PADDR=0x100 (index 64, out of range) then read PADDR=0x012 (unaligned) -> both complete with PSLVERR=1; read PRDATA=0; memory unchanged (re-read of 0x010 still returns 0x12345678).
- Back-to-back: writes of 0xA5A5A5A5 to 0x000 and 0x5A5A5A5A to 0x004 with no idle gap, then reads of both -> 3 cycles per transfer with WAIT_STATES=1; data match; with WAIT_STATES=0 each transfer takes 2 cycles.
- Abort: write 0xDEADBEEF to 0x008 with PSEL dropped during the wait cycle -> PREADY never asserts; a subsequent read of 0x008 returns 0x00000000.
- Reset mid-transfer: assert PRESETn=0 during the ACCESS of a write to 0x00C -> outputs go to 0 asynchronously; after release, a read of 0x00C returns 0 and a read of 0x010 returns 0 (memory cleared).

Source files
------------

// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB3 bus bundle between a requester (master) and apb_slave_mem (slave)
// Signals: PSEL/PENABLE/PWRITE/PADDR/PWDATA driven by the master; PRDATA/PREADY/PSLVERR driven by the slave
interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer backed by a flop word memory with WAIT_STATES wait cycles and PSLVERR on bad addresses
// Ports: PCLK clock; PRESETn async active-low reset; bus = APB slave modport (PSEL, PENABLE, PWRITE, PADDR, PWDATA in; PRDATA, PREADY, PSLVERR out)
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WORDS   = 64,
  parameter int WAIT_STATES = 1
) (
  input logic PCLK,
  input logic PRESETn,
  apb_slave_mem_if.slave bus
);
  localparam int SH = $clog2(DATA_WIDTH / 8);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << SH) - 1);
  localparam logic [ADDR_WIDTH:0] WORDS = (ADDR_WIDTH + 1)'(MEM_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic ready, write_l, err_l, setup, dec_err, we;
  logic [IW-1:0] idx_l;
  logic [ADDR_WIDTH-1:0] widx;
  logic [DATA_WIDTH-1:0] wdata_l;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  assign setup = bus.PSEL && !bus.PENABLE;
  assign widx = bus.PADDR >> SH;
  assign dec_err = (|(bus.PADDR & LOW_MASK)) || ({1'b0, widx} >= WORDS);
  // commit only on a genuine completion edge; an aborted or erroneous write never reaches memory
  assign we = state == ACCESS && ready && bus.PSEL && bus.PENABLE && write_l && !err_l;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (setup ? ACCESS : IDLE) : ((!bus.PSEL || ready) ? IDLE : ACCESS);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      cnt     <= '0;
      ready   <= 1'b0;
      write_l <= 1'b0;
      err_l   <= 1'b0;
      idx_l   <= '0;
      wdata_l <= '0;
    end else if (state == IDLE) begin
      ready <= setup && WS == 3'd0;
      if (setup) begin
        cnt     <= WS;
        write_l <= bus.PWRITE;
        err_l   <= dec_err;
        idx_l   <= widx[IW-1:0];
        wdata_l <= bus.PWDATA;
      end
    end else if (!bus.PSEL || ready) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else if (cnt != 3'd0) begin
      cnt   <= cnt - 3'd1;
      ready <= cnt == 3'd1;
    end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    else if (we) mem[idx_l] <= wdata_l;
  // outputs are decoded from registered state so reset clears them without waiting for a clock
  always_comb begin
    bus.PREADY  = ready;
    bus.PSLVERR = ready && err_l;
    bus.PRDATA  = (ready && !write_l && !err_l) ? mem[idx_l] : '0;
  end
endmodule
